// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int         XLEN          = 64;
    localparam logic [2:0] DW_ALIGN_MASK = 3'b111;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding access; o_expired flags the last permitted BUSY cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack access per load/store, stalls the pipeline
// until it completes, and returns the load result (or 0 on fault) for IR4.
module mem_access_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = XLEN,
    parameter int DATA_W  = XLEN,
    parameter int TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_IR3,
    input  logic              MemRead_IR3,
    input  logic              MemWrite_IR3,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Write_Data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_err,
    output logic              stall,
    output logic [DATA_W-1:0] Read_Data,
    output logic              mem_fault
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic              w_access;
    logic              w_aligned;
    logic              w_stall;
    logic              w_expired;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fault;

    assign w_access  = valid_IR3 & (MemRead_IR3 | MemWrite_IR3);
    assign w_aligned = ((Mem_Addr[2:0] & DW_ALIGN_MASK) == 3'b000);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clr     (r_state != BUSY),
        .i_en      (r_state == BUSY),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_stall = 1'b1;
                    w_next  = w_aligned ? BUSY : DONE;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (dmem_ack || w_expired) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Fault is set only on the transition into DONE, so it is a single-cycle pulse there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_req   <= 1'b1;
                            r_we    <= MemWrite_IR3;
                            r_addr  <= Mem_Addr;
                            r_wdata <= Write_Data;
                        end else begin
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        r_req <= 1'b0;
                        if (dmem_err) begin
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                        end else if (!r_we) begin
                            r_rdata <= dmem_rdata;
                        end
                    end else if (w_expired) begin
                        r_req   <= 1'b0;
                        r_rdata <= '0;
                        r_fault <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign Read_Data  = r_rdata;
    assign mem_fault  = r_fault;
    assign stall      = w_stall & reset;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: each access pushes its expected result, the monitor pops on DONE.
module tb_mem_access_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_IR3, MemRead_IR3, MemWrite_IR3;
    logic [63:0] Mem_Addr, Write_Data;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_ack, dmem_err;
    logic [63:0] dmem_rdata;
    logic        stall;
    logic [63:0] Read_Data;
    logic        mem_fault;

    typedef struct {
        logic [63:0] rd;
        logic        fault;
        int          stall_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_fault = 0;
    int          exp_faults = 0;
    logic [63:0] m_rd = '0;

    mem_access_ctrl #(
        .ADDR_W  (64),
        .DATA_W  (64),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_IR3    (valid_IR3),
        .MemRead_IR3  (MemRead_IR3),
        .MemWrite_IR3 (MemWrite_IR3),
        .Mem_Addr     (Mem_Addr),
        .Write_Data   (Write_Data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_err     (dmem_err),
        .stall        (stall),
        .Read_Data    (Read_Data),
        .mem_fault    (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic bubble();
        valid_IR3    = 1'b0;
        MemRead_IR3  = 1'b0;
        MemWrite_IR3 = 1'b0;
    endtask

    // delay = ack after that many wait cycles; delay < 0 means the memory never answers.
    task automatic run_acc(input logic rd_en, input logic wr_en, input logic [63:0] addr,
                           input logic [63:0] wdata, input int delay,
                           input logic [63:0] rdata, input logic err);
        exp_t e;
        logic mis;
        int   busy;
        mis  = (addr[2:0] != 3'b000);
        busy = (delay < 0) ? TMO : delay + 1;
        if (mis) begin
            m_rd = '0; e.fault = 1'b1; e.stall_cyc = 1;
        end else if (delay < 0) begin
            m_rd = '0; e.fault = 1'b1; e.stall_cyc = 1 + TMO;
        end else if (err) begin
            m_rd = '0; e.fault = 1'b1; e.stall_cyc = 1 + busy;
        end else begin
            if (!wr_en) m_rd = rdata;
            e.fault = 1'b0; e.stall_cyc = 1 + busy;
        end
        e.rd = m_rd;
        if (e.fault) exp_faults++;
        sbq.push_back(e);

        @(negedge clk);
        valid_IR3    = 1'b1;
        MemRead_IR3  = rd_en;
        MemWrite_IR3 = wr_en;
        Mem_Addr     = addr;
        Write_Data   = wdata;
        #1;
        chk("idle_stall", stall, 1);
        chk("idle_req", dmem_req, 0);
        if (!mis) begin
            for (int c = 0; c < busy; c++) begin
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_err   = 1'b0;
                Mem_Addr   = ~addr;
                Write_Data = ~wdata;
                #1;
                chk("busy_req", dmem_req, 1);
                chk("busy_addr", dmem_addr, addr);
                chk("busy_wdata", dmem_wdata, wdata);
                chk("busy_we", dmem_we, wr_en);
                if (c == delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                    dmem_err   = err;
                end
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_err = 1'b0;
        bubble();
        #1;
        chk("done_req", dmem_req, 0);
    endtask

    // Monitor: a DONE cycle is the first non-stalled cycle after a stalled run.
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                run = 0;
            end else if (stall) begin
                run++;
            end else if (run > 0) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("done_rdata", Read_Data, e.rd);
                    chk("done_fault", mem_fault, e.fault);
                    chk("stall_cycles", 64'(run), 64'(e.stall_cyc));
                end
                run = 0;
            end
            if (reset && mem_fault) n_fault++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        valid_IR3    = 1'b1;
        MemRead_IR3  = 1'b1;
        MemWrite_IR3 = 1'b0;
        Mem_Addr     = 64'h40;
        Write_Data   = '0;
        dmem_ack     = 1'b0;
        dmem_err     = 1'b0;
        dmem_rdata   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_rdata", Read_Data, 0);
        chk("rst_fault", mem_fault, 0);
        bubble();
        @(negedge clk);
        reset = 1'b1;

        run_acc(1, 0, 64'h40, 64'h0, 0, 64'hDEAD_BEEF, 0);
        run_acc(0, 1, 64'h80, 64'h1234, 4, 64'hBAD0_BAD0, 0);
        run_acc(1, 0, 64'h43, 64'h0, 0, 64'h0, 0);
        run_acc(1, 0, 64'h48, 64'h0, 1, 64'hCAFE, 0);
        run_acc(1, 0, 64'h100, 64'h0, -1, 64'h0, 0);
        repeat (2) @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h55;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("late_ack_rdata", Read_Data, 0);
        chk("late_ack_stall", stall, 0);
        run_acc(1, 0, 64'h18, 64'h0, 0, 64'h1111, 0);
        run_acc(1, 0, 64'h20, 64'h0, 2, 64'hFFFF, 1);
        run_acc(1, 1, 64'h10, 64'h7777, 1, 64'h9999, 0);
        run_acc(1, 0, 64'h58, 64'h0, 0, 64'hABCD, 0);

        @(negedge clk);
        valid_IR3   = 1'b1;
        MemRead_IR3 = 1'b1;
        Mem_Addr    = 64'h200;
        Write_Data  = 64'h3;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_req", dmem_req, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_addr", dmem_addr, 0);
        chk("midrst_rdata", Read_Data, 0);
        chk("midrst_fault", mem_fault, 0);
        m_rd = '0;
        bubble();
        @(negedge clk);
        reset      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h4444;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("post_rst_stall", stall, 0);
        chk("post_rst_req", dmem_req, 0);
        chk("post_rst_rdata", Read_Data, 0);
        run_acc(1, 0, 64'h2F0, 64'h0, 0, 64'h2222, 0);

        run_acc(1, 0, 64'h00, 64'h0, 0, 64'hA0A0, 0);
        run_acc(1, 0, 64'h08, 64'h0, 1, 64'hB0B0, 0);

        repeat (3) @(negedge clk);
        chk("sb_left", 64'(sbq.size()), 64'd0);
        chk("fault_pulses", 64'(n_fault), 64'(exp_faults));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
